// File: rtl/sa_pkg.sv
// Shared types and sizing for the systolic-array controller and its operand feeder.
package sa_pkg;

    localparam int N_DEF = 4;
    localparam int W_DEF = 32;
    localparam int ACC_W = 2 * W_DEF;
    localparam int CNT_W = $clog2(3 * N_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_FEED  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Feed counter must hold 0 .. 3N-3 for any array size.
    function automatic int feed_cnt_w(input int n);
        return $clog2(3 * n);
    endfunction

endpackage

// File: rtl/sa_skew_feeder.sv
// Operand buffers for A and B plus the diagonally skewed row/column read-out.
module sa_skew_feeder
    import sa_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int W  = W_DEF,
    parameter int CW = feed_cnt_w(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en_i,
    input  logic                 wr_sel_i,
    input  logic [$clog2(N)-1:0] wr_row_i,
    input  logic [$clog2(N)-1:0] wr_col_i,
    input  logic [W-1:0]         wr_data_i,
    input  logic                 feed_en_i,
    input  logic [CW-1:0]        t_i,
    output logic [N*W-1:0]       west_data_o,
    output logic [N*W-1:0]       north_data_o
);

    logic [W-1:0]   a_mem_q [N][N];
    logic [W-1:0]   b_mem_q [N][N];
    logic [N*W-1:0] west_d;
    logic [N*W-1:0] north_d;
    logic [N*W-1:0] west_q;
    logic [N*W-1:0] north_q;
    logic           hit_s;

    // Operand storage keeps its contents through reset so reruns reuse it.
    always_ff @(posedge clk) begin
        if (wr_en_i && !wr_sel_i) begin
            a_mem_q[wr_row_i][wr_col_i] <= wr_data_i;
        end
        if (wr_en_i && wr_sel_i) begin
            b_mem_q[wr_row_i][wr_col_i] <= wr_data_i;
        end
    end

    // Row i / column i carry element k when t == i + k; at most one k matches.
    always_comb begin
        west_d  = '0;
        north_d = '0;
        hit_s   = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                hit_s = feed_en_i && (t_i == CW'(i + k));
                west_d[i*W +: W]  = west_d[i*W +: W]  | ({W{hit_s}} & a_mem_q[i][k]);
                north_d[i*W +: W] = north_d[i*W +: W] | ({W{hit_s}} & b_mem_q[k][i]);
            end
        end
    end

    // Registered feeds toward the array edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            west_q  <= '0;
            north_q <= '0;
        end else begin
            west_q  <= west_d;
            north_q <= north_d;
        end
    end

    assign west_data_o  = west_q;
    assign north_data_o = north_q;

endmodule

// File: rtl/systolic_controller.sv
// Run sequencer for an NxN output-stationary systolic array: clear, skewed feed, done.
module systolic_controller
    import sa_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 ld_en,
    input  logic                 ld_sel,
    input  logic [$clog2(N)-1:0] ld_row,
    input  logic [$clog2(N)-1:0] ld_col,
    input  logic [W-1:0]         ld_data,
    output logic [N*W-1:0]       west_data,
    output logic [N*W-1:0]       north_data,
    output logic                 arr_clr,
    output logic                 busy,
    output logic                 done,
    output logic                 result_valid
);

    localparam int CW = feed_cnt_w(N);
    localparam logic [CW-1:0] T_LAST = CW'(3 * N - 3);

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] t_q;
    logic [CW-1:0] t_d;
    logic          arr_clr_q;
    logic          busy_q;
    logic          done_q;
    logic          result_valid_q;
    logic          feed_en_s;
    logic          wr_en_s;

    // Next-state and feed-counter selection.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
                t_d = '0;
            end
            ST_CLEAR: begin
                state_d = ST_FEED;
                t_d     = '0;
            end
            ST_FEED: begin
                if (t_q == T_LAST) begin
                    state_d = ST_DONE;
                    t_d     = '0;
                end else begin
                    state_d = ST_FEED;
                    t_d     = t_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                t_d     = '0;
            end
            default: begin
                state_d = ST_IDLE;
                t_d     = '0;
            end
        endcase
    end

    assign feed_en_s = (state_d == ST_FEED);
    assign wr_en_s   = ld_en && !busy_q;

    // State register with outputs decoded from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            t_q            <= '0;
            arr_clr_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            arr_clr_q <= (state_d == ST_CLEAR);
            busy_q    <= (state_d == ST_CLEAR) || (state_d == ST_FEED);
            done_q    <= (state_d == ST_DONE);
            if (state_d == ST_DONE) begin
                result_valid_q <= 1'b1;
            end else if (state_d == ST_CLEAR) begin
                result_valid_q <= 1'b0;
            end else begin
                result_valid_q <= result_valid_q;
            end
        end
    end

    sa_skew_feeder #(
        .N (N),
        .W (W),
        .CW(CW)
    ) u_feeder (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (wr_en_s),
        .wr_sel_i    (ld_sel),
        .wr_row_i    (ld_row),
        .wr_col_i    (ld_col),
        .wr_data_i   (ld_data),
        .feed_en_i   (feed_en_s),
        .t_i         (t_d),
        .west_data_o (west_data),
        .north_data_o(north_data)
    );

    assign arr_clr      = arr_clr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_systolic_controller.sv
// Bench: drives systolic_controller, runs a behavioural NxN array on its feeds, scoreboards C = A*B.
module tb_systolic_controller;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           ld_en;
    logic           ld_sel;
    logic [1:0]     ld_row;
    logic [1:0]     ld_col;
    logic [W-1:0]   ld_data;
    logic [N*W-1:0] west_data;
    logic [N*W-1:0] north_data;
    logic           arr_clr;
    logic           busy;
    logic           done;
    logic           result_valid;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [31:0] ma [N][N];
    logic [31:0] mb [N][N];
    logic [63:0] exp_q [$];
    logic [63:0] saved [N*N];

    systolic_controller #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ld_en       (ld_en),
        .ld_sel      (ld_sel),
        .ld_row      (ld_row),
        .ld_col      (ld_col),
        .ld_data     (ld_data),
        .west_data   (west_data),
        .north_data  (north_data),
        .arr_clr     (arr_clr),
        .busy        (busy),
        .done        (done),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    // Behavioural output-stationary array fed by the controller.
    logic                 arr_rst;
    logic [N*N*W-1:0]     a_flat;
    logic [N*N*W-1:0]     b_flat;
    logic [N*N*64-1:0]    acc_flat;
    assign arr_rst = rst | arr_clr;

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic [W-1:0] a_in, b_in, a_q, b_q;
            logic [63:0]  acc_q;
            if (gj == 0) begin : g_w
                assign a_in = west_data[gi*W +: W];
            end else begin : g_e
                assign a_in = a_flat[(gi*N+gj-1)*W +: W];
            end
            if (gi == 0) begin : g_n
                assign b_in = north_data[gj*W +: W];
            end else begin : g_s
                assign b_in = b_flat[((gi-1)*N+gj)*W +: W];
            end
            assign a_flat[(gi*N+gj)*W +: W]     = a_q;
            assign b_flat[(gi*N+gj)*W +: W]     = b_q;
            assign acc_flat[(gi*N+gj)*64 +: 64] = acc_q;
            always @(posedge clk or posedge arr_rst) begin
                if (arr_rst) begin
                    a_q <= '0; b_q <= '0; acc_q <= '0;
                end else begin
                    a_q   <= a_in;
                    b_q   <= b_in;
                    acc_q <= acc_q + 64'(a_in) * 64'(b_in);
                end
            end
        end
    end

    function automatic logic [63:0] acc_at(input int i, input int j);
        return acc_flat[(i*N+j)*64 +: 64];
    endfunction

    function automatic logic [31:0] val(input int mode, input int r, input int c);
        case (mode)
            0:       return (r == c) ? 32'd1 : 32'd0;
            1:       return 32'(4*r + c);
            2:       return 32'd1;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'(2*(4*r + c));
            default: return 32'd0;
        endcase
    endfunction

    task automatic load(input logic sel, input int mode, input bit skip_last);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (!(skip_last && r == N-1 && c == N-1)) begin
                    @(negedge clk);
                    ld_en = 1'b1; ld_sel = sel; ld_row = 2'(r); ld_col = 2'(c);
                    ld_data = val(mode, r, c);
                    if (sel) mb[r][c] = ld_data; else ma[r][c] = ld_data;
                end
            end
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic push_expected();
        logic [63:0] s;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 64'd0;
                for (int k = 0; k < N; k++) s = s + 64'(ma[i][k]) * 64'(mb[k][j]);
                exp_q.push_back(s);
            end
        end
    endtask

    // One run: optional write alongside start, optional start+write injected at cycle inj.
    task automatic run(input string nm, input bit co_wr, input logic [1:0] co_row,
                       input logic [1:0] co_col, input logic [31:0] co_data, input int inj);
        int cyc, clr_cnt;
        bit got;
        logic [63:0] e;
        @(negedge clk);
        start = 1'b1;
        if (co_wr) begin
            ld_en = 1'b1; ld_sel = 1'b1; ld_row = co_row; ld_col = co_col; ld_data = co_data;
            mb[co_row][co_col] = co_data;
        end
        push_expected();
        @(negedge clk);
        start = 1'b0; ld_en = 1'b0;
        cyc = 1; clr_cnt = 0; got = 1'b0;
        while (cyc <= 3*N + 4 && !got) begin
            if (arr_clr) clr_cnt++;
            if (done) begin
                got = 1'b1;
                vec_cnt++;
                if (cyc != 3*N) begin
                    err_cnt++; $display("FAIL %s done_cycle: got %0d want %0d", nm, cyc, 3*N);
                end
                vec_cnt++;
                if (result_valid !== 1'b1) begin
                    err_cnt++; $display("FAIL %s result_valid: got %b want 1", nm, result_valid);
                end
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        e = exp_q.pop_front();
                        vec_cnt++;
                        if (acc_at(i, j) !== e) begin
                            err_cnt++;
                            $display("FAIL %s C[%0d][%0d]: got %h want %h", nm, i, j, acc_at(i, j), e);
                        end
                    end
                end
            end else begin
                vec_cnt++;
                if (busy !== 1'b1) begin
                    err_cnt++; $display("FAIL %s busy@%0d: got %b want 1", nm, cyc, busy);
                end
                if (cyc == 1) begin
                    vec_cnt++;
                    if (west_data !== '0 || north_data !== '0) begin
                        err_cnt++; $display("FAIL %s feed_in_clear: got %h/%h want 0", nm, west_data, north_data);
                    end
                end
                if (cyc == inj) begin
                    start = 1'b1; ld_en = 1'b1; ld_sel = 1'b0; ld_row = 2'd0; ld_col = 2'd0; ld_data = 32'd7;
                end
                @(negedge clk);
                start = 1'b0; ld_en = 1'b0;
                cyc++;
            end
        end
        if (!got) begin
            vec_cnt++; err_cnt++;
            $display("FAIL %s timeout: got no done want done at %0d", nm, 3*N);
            repeat (N*N) void'(exp_q.pop_front());
        end
        vec_cnt++;
        if (clr_cnt != 1) begin
            err_cnt++; $display("FAIL %s arr_clr_pulses: got %0d want 1", nm, clr_cnt);
        end
        @(negedge clk);
        vec_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b1 || west_data !== '0 || north_data !== '0) begin
            err_cnt++;
            $display("FAIL %s after_done: got done=%b busy=%b rv=%b feeds=%h/%h want 0 0 1 0/0",
                     nm, done, busy, result_valid, west_data, north_data);
        end
    endtask

    task automatic test_reset();
        vec_cnt++;
        if ({busy, done, result_valid, arr_clr} !== 4'b0000 || west_data !== '0 || north_data !== '0) begin
            err_cnt++;
            $display("FAIL reset_state: got busy=%b done=%b rv=%b clr=%b feeds=%h/%h want all 0",
                     busy, done, result_valid, arr_clr, west_data, north_data);
        end
    endtask

    task automatic test_identity();
        load(1'b0, 0, 1'b0);
        load(1'b1, 1, 1'b0);
        run("identity", 1'b0, 2'd0, 2'd0, 32'd0, -1);
        vec_cnt++;
        if (acc_at(3, 2) !== 64'd14) begin
            err_cnt++; $display("FAIL identity C32: got %0d want 14", acc_at(3, 2));
        end
    endtask

    task automatic test_ones();
        load(1'b0, 2, 1'b0);
        load(1'b1, 2, 1'b0);
        run("ones", 1'b0, 2'd0, 2'd0, 32'd0, -1);
        vec_cnt++;
        if (acc_at(1, 3) !== 64'd4) begin
            err_cnt++; $display("FAIL ones C13: got %0d want 4", acc_at(1, 3));
        end
    endtask

    task automatic test_max_wrap();
        load(1'b0, 3, 1'b0);
        load(1'b1, 3, 1'b0);
        run("max_wrap", 1'b0, 2'd0, 2'd0, 32'd0, -1);
        vec_cnt++;
        if (acc_at(2, 1) !== 64'hFFFF_FFF8_0000_0004) begin
            err_cnt++; $display("FAIL max_wrap C21: got %h want fffffff800000004", acc_at(2, 1));
        end
    endtask

    task automatic test_busy_ignore();
        load(1'b0, 0, 1'b0);
        load(1'b1, 1, 1'b0);
        run("busy_ignore", 1'b0, 2'd0, 2'd0, 32'd0, 5);
        run("busy_rerun", 1'b0, 2'd0, 2'd0, 32'd0, -1);
    endtask

    task automatic test_abort();
        int seen;
        load(1'b0, 2, 1'b0);
        load(1'b1, 1, 1'b0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        vec_cnt++;
        if ({busy, done, result_valid, arr_clr} !== 4'b0000 || west_data !== '0 || north_data !== '0) begin
            err_cnt++;
            $display("FAIL abort_drop: got busy=%b done=%b rv=%b clr=%b feeds=%h/%h want all 0",
                     busy, done, result_valid, arr_clr, west_data, north_data);
        end
        @(negedge clk); rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 3*N + 2; c++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        vec_cnt++;
        if (seen != 0) begin
            err_cnt++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen);
        end
        run("post_abort", 1'b0, 2'd0, 2'd0, 32'd0, -1);
    endtask

    task automatic test_back_to_back();
        load(1'b0, 1, 1'b0);
        load(1'b1, 1, 1'b0);
        run("b2b_first", 1'b0, 2'd0, 2'd0, 32'd0, -1);
        for (int i = 0; i < N*N; i++) saved[i] = acc_at(i / N, i % N);
        load(1'b1, 4, 1'b1);
        run("b2b_second", 1'b1, 2'd3, 2'd3, val(4, 3, 3), -1);
        for (int i = 0; i < N*N; i++) begin
            vec_cnt++;
            if (acc_at(i / N, i % N) !== (saved[i] << 1)) begin
                err_cnt++;
                $display("FAIL b2b_double[%0d]: got %h want %h", i, acc_at(i / N, i % N), saved[i] << 1);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ld_en = 1'b0; ld_sel = 1'b0;
        ld_row = 2'd0; ld_col = 2'd0; ld_data = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_identity();
        test_ones();
        test_max_wrap();
        test_busy_ignore();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/systolic_controller.md
SYSTOLIC_CONTROLLER -- requirements
Module: systolic_controller

Interface
REQ-001 SHALL have parameter N, default 4, meaning array dimension (NxN processing elements).
REQ-002 SHALL have parameter W, default 32, meaning operand width in bits.
REQ-003 SHALL have port clk  input  1  clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a multiply.
REQ-006 SHALL have port ld_en  input  1  operand write strobe.
REQ-007 SHALL have port ld_sel  input  1  operand select: 0 = matrix A, 1 = matrix B.
REQ-008 SHALL have ports ld_row and ld_col  input  clog2(N) each  element index.
REQ-009 SHALL have port ld_data  input  W  element value.
REQ-010 SHALL have port west_data  output  N*W  row feed; slice i drives the west input of array row i.
REQ-011 SHALL have port north_data  output  N*W  column feed; slice j drives the north input of array column j.
REQ-012 SHALL have port arr_clr  output  1  array accumulator clear; the integrator ORs it with rst into the array reset.
REQ-013 SHALL have ports busy, done, result_valid  output  1 each: run in progress; one-cycle completion pulse; array results stable.

Function
REQ-014 SHALL implement states IDLE, CLEAR, FEED and DONE.
REQ-015 IDLE: start=1 SHALL move to CLEAR; start in any other state SHALL be ignored.
REQ-016 CLEAR SHALL last exactly 1 cycle with arr_clr=1, then enter FEED with feed counter t=0.
REQ-017 FEED SHALL last 3N-2 cycles (t = 0 .. 3N-3), then enter DONE.
REQ-018 During FEED cycle t: west slice i = A[i][t-i] if 0 <= t-i < N, else 0; north slice j = B[t-j][j] if 0 <= t-j < N, else 0.
REQ-019 west_data and north_data SHALL be registered outputs, and SHALL be 0 in every state other than FEED.
REQ-020 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-021 done SHALL be asserted exactly 3N cycles after the edge that samples start (12 cycles for N=4).
REQ-022 busy SHALL be 1 in CLEAR and FEED, and 0 in IDLE and DONE.
REQ-023 result_valid SHALL set on entry to DONE and clear on entry to CLEAR.
REQ-024 ld_en SHALL write ld_data to A[ld_row][ld_col] or B[ld_row][ld_col] only when busy=0; when busy=1 the write SHALL be dropped.
REQ-025 A write and start in the same IDLE cycle SHALL both take effect, with the write visible to the run.
REQ-026 Operand buffers SHALL retain their contents across runs; a run with no reloads SHALL reproduce the previous result.

Reset
REQ-027 rst SHALL force state IDLE, t=0, west_data=0, north_data=0, arr_clr=0, busy=0, done=0 and result_valid=0.
REQ-028 Operand buffers SHALL NOT be reset.
REQ-029 rst asserted mid-FEED SHALL abort the run immediately; no done pulse SHALL follow.

Structure
REQ-030 Shared package sa_pkg SHALL hold the defaults for N and W, the state enum, the accumulator width 2W, and the feed-count width clog2(3N).
REQ-031 The A/B operand storage and the skewed read-out SHALL be one sub-module, sa_skew_feeder; the FSM and counter SHALL remain in systolic_controller.

Verification
REQ-032 N=4, A = identity, B[k][j] = 4k+j, start -> done at cycle 12; array results C[i][j] = 4i+j.
REQ-033 All A and B elements = 1 -> every C[i][j] = 4; west_data and north_data are 0 outside FEED.
REQ-034 All A and B elements = 0xFFFFFFFF -> every 64-bit C[i][j] = 0xFFFFFFF800000004 (wraps modulo 2^64).
REQ-035 Pulse start at FEED t=3 and ld_en with ld_data=7 -> no restart, operand buffers unchanged, done still at cycle 12.
REQ-036 Assert rst at FEED t=5 -> busy, done and the feeds drop to 0; a new start then gives correct results with no residue from the aborted run.
REQ-037 Two back-to-back runs, the second with B = 2*B -> arr_clr pulses once per run; the second results are exactly double the first.
